// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and sizing helpers for the reset sequencer
package reset_seq_pkg;

    localparam int HOLD_CYC_DEF = 16;
    localparam int TMO_CYC_DEF  = 255;

    typedef enum logic [2:0] {
        RS_HOLD  = 3'd0,
        RS_REL   = 3'd1,
        RS_WACK  = 3'd2,
        RS_GAP   = 3'd3,
        RS_IDLE  = 3'd4,
        RS_FAULT = 3'd5
    } rs_state_e;

    // One counter serves hold, ack-timeout and gap, so it is sized for the largest of the three.
    function automatic int cnt_width(int hold_cyc, int tmo_cyc, int gap_w);
        int m;
        m = hold_cyc;
        if (tmo_cyc > m) m = tmo_cyc;
        if ((1 << gap_w) > m) m = 1 << gap_w;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int idx_width(int num_dom);
        return (num_dom > 1) ? $clog2(num_dom) : 1;
    endfunction

endpackage

// File: rtl/reset_seq_ctrl_if.sv
// rtl/reset_seq_ctrl_if.sv - control, ack and reset-net bundle of the reset sequencer
interface reset_seq_ctrl_if
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOM = 4,
    parameter int GAP_W   = 8
);
    localparam int IW = idx_width(NUM_DOM);

    logic               sw_req;
    logic [GAP_W-1:0]   gap_cfg;
    logic [NUM_DOM-1:0] dom_ack;
    logic [NUM_DOM-1:0] dom_reset;
    logic               busy;
    logic               done;
    logic               fault;
    logic [IW-1:0]      fault_dom;

    modport master (
        input  sw_req, gap_cfg, dom_ack,
        output dom_reset, busy, done, fault, fault_dom
    );

    modport slave (
        output sw_req, gap_cfg, dom_ack,
        input  dom_reset, busy, done, fault, fault_dom
    );

endinterface

// File: rtl/rs_down_counter.sv
// rtl/rs_down_counter.sv - loadable up/down cycle counter with zero terminal-count flag
module rs_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (inc) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (dec) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == '0);

endmodule

// File: rtl/reset_seq_ctrl.sv
// rtl/reset_seq_ctrl.sv - holds all reset domains, then releases them in index order with ack and gap
module reset_seq_ctrl
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOM  = 4,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int GAP_W    = 8,
    parameter int TMO_CYC  = TMO_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    reset_seq_ctrl_if.master bus
);

    localparam int CW = cnt_width(HOLD_CYC, TMO_CYC, GAP_W);
    localparam int IW = idx_width(NUM_DOM);

    rs_state_e          state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_DOM-1:0] dom_reset_q, dom_reset_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;
    logic [IW-1:0]      fault_dom_q, fault_dom_d;
    logic               busy;

    logic               cnt_clr, cnt_load, cnt_inc, cnt_dec;
    logic [CW-1:0]      cnt;
    logic               cnt_tc;

    rs_down_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (CW'(bus.gap_cfg)),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RS_HOLD;
            idx_q       <= '0;
            dom_reset_q <= '1;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            fault_dom_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dom_reset_q <= dom_reset_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            fault_dom_q <= fault_dom_d;
        end
    end

    // A software restart overrides whatever the current state would have done this cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        cnt_dec  = 1'b0;
        if (bus.sw_req) begin
            state_d = RS_HOLD;
            idx_d   = '0;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                RS_HOLD: begin
                    if (cnt == CW'(HOLD_CYC - 1)) begin
                        state_d = RS_REL;
                        idx_d   = '0;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                RS_REL: begin
                    cnt_clr = 1'b1;
                    state_d = RS_WACK;
                end
                RS_WACK: begin
                    if (bus.dom_ack[idx_q]) begin
                        if (idx_q == IW'(NUM_DOM - 1)) begin
                            state_d = RS_IDLE;
                        end else begin
                            cnt_load = 1'b1;
                            state_d  = RS_GAP;
                        end
                    end else if (cnt == CW'(TMO_CYC - 1)) begin
                        state_d = RS_FAULT;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                RS_GAP: begin
                    if (cnt_tc) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = RS_REL;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // The domain's reset drops on entry to REL, so the release is visible during the REL cycle itself.
    always_comb begin
        dom_reset_d = dom_reset_q;
        done_d      = 1'b0;
        fault_d     = fault_q;
        fault_dom_d = fault_dom_q;
        case (state_q)
            RS_HOLD, RS_REL, RS_WACK, RS_GAP: busy = 1'b1;
            default:                          busy = 1'b0;
        endcase
        if (bus.sw_req) begin
            dom_reset_d = '1;
            fault_d     = 1'b0;
            fault_dom_d = '0;
        end else begin
            case (state_d)
                RS_REL: begin
                    if (state_q != RS_REL) dom_reset_d[idx_d] = 1'b0;
                end
                RS_IDLE: begin
                    dom_reset_d = '0;
                    done_d      = (state_q == RS_WACK);
                end
                RS_FAULT: begin
                    dom_reset_d = '1;
                    fault_d     = 1'b1;
                    if (state_q == RS_WACK) fault_dom_d = idx_q;
                end
                default: begin
                    dom_reset_d = dom_reset_q;
                end
            endcase
        end
    end

    assign bus.dom_reset = dom_reset_q;
    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.fault_dom = fault_dom_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// tb/tb_reset_seq_ctrl.sv - directed self-checking bench for reset_seq_ctrl
module tb_reset_seq_ctrl;

    logic clk;
    logic reset;

    reset_seq_ctrl_if #(.NUM_DOM(4), .GAP_W(8)) bus ();

    reset_seq_ctrl #(
        .NUM_DOM  (4),
        .HOLD_CYC (16),
        .GAP_W    (8),
        .TMO_CYC  (255)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int         n_checks;
    int         n_fail;
    int         cyc;
    int         done_cnt;
    int         low_cnt [4];
    logic [3:0] ack_en;
    logic       ack_tie;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Acks follow each domain's release by two cycles unless tied high.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.done) done_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (bus.dom_reset[i] == 1'b0) low_cnt[i]++;
            else                          low_cnt[i] = 0;
            bus.dom_ack[i] = ack_tie | (ack_en[i] & (low_cnt[i] > 2));
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.sw_req = 1'b0;
        bus.dom_ack = ack_tie ? 4'hF : 4'h0;
        for (int i = 0; i < 4; i++) low_cnt[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        done_cnt = 0;
    endtask

    task automatic sw_pulse();
        bus.sw_req = 1'b1;
        tick();
        bus.sw_req = 1'b0;
        cyc = 0;
        done_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        done_cnt = 0;
        ack_en = 4'hF;
        ack_tie = 1'b0;
        bus.gap_cfg = 8'd3;
        bus.sw_req = 1'b0;
        bus.dom_ack = 4'h0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_dom_reset", 32'(bus.dom_reset), 32'hF);
        check_eq("rst_busy", 32'(bus.busy), 32'd1);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_fault", 32'(bus.fault), 32'd0);
        check_eq("rst_fault_dom", 32'(bus.fault_dom), 32'd0);

        // nominal bring-up, gap 3
        do_reset();
        run_to(15);  check_eq("nom_hold_c15", 32'(bus.dom_reset), 32'hF);
        run_to(16);  check_eq("nom_rel0_c16", 32'(bus.dom_reset), 32'hE);
        run_to(22);  check_eq("nom_c22", 32'(bus.dom_reset), 32'hE);
        run_to(23);  check_eq("nom_rel1_c23", 32'(bus.dom_reset), 32'hC);
        run_to(30);  check_eq("nom_rel2_c30", 32'(bus.dom_reset), 32'h8);
        run_to(37);  check_eq("nom_rel3_c37", 32'(bus.dom_reset), 32'h0);
        run_to(39);  check_eq("nom_busy_c39", 32'(bus.busy), 32'd1);
                     check_eq("nom_done_c39", 32'(bus.done), 32'd0);
        run_to(40);  check_eq("nom_done_c40", 32'(bus.done), 32'd1);
                     check_eq("nom_busy_c40", 32'(bus.busy), 32'd0);
        run_to(45);  check_eq("nom_done_pulses", 32'(done_cnt), 32'd1);
                     check_eq("nom_idle_dom_reset", 32'(bus.dom_reset), 32'h0);

        // restart while in GAP after domain 1 acked
        do_reset();
        run_to(27);  check_eq("rst_mid_pre", 32'(bus.dom_reset), 32'hC);
        sw_pulse();
        check_eq("rst_mid_dom_reset", 32'(bus.dom_reset), 32'hF);
        check_eq("rst_mid_busy", 32'(bus.busy), 32'd1);
        run_to(15);  check_eq("rst_mid_hold_c15", 32'(bus.dom_reset), 32'hF);
        run_to(16);  check_eq("rst_mid_rel0_c16", 32'(bus.dom_reset), 32'hE);
        run_to(40);  check_eq("rst_mid_done_c40", 32'(bus.done), 32'd1);
                     check_eq("rst_mid_done_pulses", 32'(done_cnt), 32'd1);

        // sw_req coincides with last-domain ack
        do_reset();
        run_to(39);  check_eq("simul_ack3", 32'(bus.dom_ack[3]), 32'd1);
        sw_pulse();
        check_eq("simul_done", 32'(bus.done), 32'd0);
        check_eq("simul_busy", 32'(bus.busy), 32'd1);
        check_eq("simul_dom_reset", 32'(bus.dom_reset), 32'hF);
        run_to(5);   check_eq("simul_no_done", 32'(done_cnt), 32'd0);
        run_to(16);  check_eq("simul_replay_c16", 32'(bus.dom_reset), 32'hE);

        // zero gap with acks tied high
        ack_tie = 1'b1;
        bus.gap_cfg = 8'd0;
        do_reset();
        run_to(16);  check_eq("zg_rel0", 32'(bus.dom_reset), 32'hE);
        run_to(18);  check_eq("zg_c18", 32'(bus.dom_reset), 32'hE);
        run_to(19);  check_eq("zg_rel1", 32'(bus.dom_reset), 32'hC);
        run_to(22);  check_eq("zg_rel2", 32'(bus.dom_reset), 32'h8);
        run_to(25);  check_eq("zg_rel3", 32'(bus.dom_reset), 32'h0);
        run_to(26);  check_eq("zg_done_c26", 32'(bus.done), 32'd0);
        run_to(27);  check_eq("zg_done_c27", 32'(bus.done), 32'd1);
                     check_eq("zg_busy_c27", 32'(bus.busy), 32'd0);
        ack_tie = 1'b0;
        bus.gap_cfg = 8'd3;

        // domain 2 never acks
        ack_en = 4'b1011;
        do_reset();
        run_to(30);  check_eq("tmo_rel2", 32'(bus.dom_reset), 32'h8);
        run_to(285); check_eq("tmo_fault_c285", 32'(bus.fault), 32'd0);
                     check_eq("tmo_busy_c285", 32'(bus.busy), 32'd1);
        run_to(286); check_eq("tmo_fault_c286", 32'(bus.fault), 32'd1);
                     check_eq("tmo_fault_dom", 32'(bus.fault_dom), 32'd2);
                     check_eq("tmo_dom_reset", 32'(bus.dom_reset), 32'hF);
                     check_eq("tmo_busy", 32'(bus.busy), 32'd0);
        run_to(300); check_eq("tmo_sticky", 32'(bus.fault), 32'd1);
                     check_eq("tmo_no_done", 32'(done_cnt), 32'd0);
        ack_en = 4'hF;
        sw_pulse();
        check_eq("flt_sw_fault", 32'(bus.fault), 32'd0);
        check_eq("flt_sw_busy", 32'(bus.busy), 32'd1);
        check_eq("flt_sw_dom_reset", 32'(bus.dom_reset), 32'hF);
        run_to(16);  check_eq("flt_replay_c16", 32'(bus.dom_reset), 32'hE);
        run_to(40);  check_eq("flt_replay_done", 32'(done_cnt), 32'd1);

        // async reset while waiting for domain 0 ack
        do_reset();
        run_to(17);  check_eq("async_pre", 32'(bus.dom_reset), 32'hE);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_dom_reset", 32'(bus.dom_reset), 32'hF);
        check_eq("async_fault", 32'(bus.fault), 32'd0);
        check_eq("async_busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        done_cnt = 0;
        run_to(15);  check_eq("async_hold_c15", 32'(bus.dom_reset), 32'hF);
        run_to(16);  check_eq("async_rel0_c16", 32'(bus.dom_reset), 32'hE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
